// File: rtl/hp_vpu_axil_csr_bridge.sv
// -----------------------------------------------------------------------------
// hp_vpu_axil_csr_bridge
//
// AXI4-Lite slave in front of the VPU CSR register port. AW and W are buffered
// independently. A small FSM then arbitrates one buffered write against one
// pending read, and runs a single CSR access (req/gnt, then error or
// rdata/rvalid). Each access is bounded by a timeout. The result is returned as
// an AXI response that is held until the master accepts it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_aw* / s_w* / s_b*         AXI4-Lite write address, data and response
//   s_ar* / s_r*                AXI4-Lite read address and data/response
//   reg_req_o / reg_gnt_i       CSR request (held until grant) and grant
//   reg_we_o, reg_addr_o,       CSR write enable, 12-bit byte address,
//   reg_wdata_o, reg_be_o       write data, byte enables (copied from WSTRB)
//   reg_rdata_i, reg_rvalid_i   CSR read data and its qualifier
//   reg_error_i                 CSR access error
// -----------------------------------------------------------------------------
module hp_vpu_axil_csr_bridge #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,

    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,

    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,

    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,

    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,

    output logic              reg_req_o,
    input  logic              reg_gnt_i,
    output logic              reg_we_o,
    output logic [11:0]       reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    output logic [3:0]        reg_be_o,
    input  logic [31:0]       reg_rdata_i,
    input  logic              reg_rvalid_i,
    input  logic              reg_error_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One spare bit so that the counter can keep running in WAIT after a late
    // grant without wrapping back below the limit.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // The CSR space is word-addressed and only 4 KiB large. Anything
    // unaligned or outside that window is rejected without touching the CSRs.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 12) != '0);
    endfunction

    // ------------------------------------------------------------------
    // Write address / write data holding buffers
    // ------------------------------------------------------------------
    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_full_q,  w_full_d;
    logic [31:0]       w_data_q,  w_data_d;
    logic [3:0]        w_strb_q,  w_strb_d;

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              prio_wr_q;   // 1: a write wins the next tie
    logic              is_wr_q;     // transaction in flight is a write
    logic [CNT_W-1:0]  cnt_q;

    logic              req_q;
    logic              we_q;
    logic [11:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    logic              wr_cand;
    logic              take_wr;
    logic              take_rd;
    logic              b_hs;
    logic              r_hs;

    assign wr_cand   = aw_full_q && w_full_q;
    assign s_awready = !aw_full_q;
    assign s_wready  = !w_full_q;
    assign s_arready = (state_q == ST_IDLE) && !(wr_cand && prio_wr_q);

    // A lone candidate always wins; on a tie the prio flag decides.
    assign take_rd = s_arvalid && s_arready;
    assign take_wr = (state_q == ST_IDLE) && wr_cand && (prio_wr_q || !s_arvalid);

    assign b_hs = bvalid_q && s_bready;
    assign r_hs = rvalid_q && s_rready;

    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_rvalid    = rvalid_q;
    assign s_rresp     = rresp_q;
    assign s_rdata     = rdata_q;
    assign reg_req_o   = req_q;
    assign reg_we_o    = we_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_be_o    = be_q;

    // Buffers drain only when the write response is accepted. AW and W can
    // therefore refill during a read, but not while their own write is open.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (b_hs) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (s_awvalid && s_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prio_wr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_wr) begin
                        is_wr_q <= 1'b1;
                        if (addr_bad(aw_addr_q)) begin
                            state_q  <= ST_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_SLVERR;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            we_q    <= 1'b1;
                            addr_q  <= aw_addr_q[11:0];
                            wdata_q <= w_data_q;
                            be_q    <= w_strb_q;
                        end
                    end else if (take_rd) begin
                        is_wr_q <= 1'b0;
                        // Cleared up front so that error and timeout paths
                        // return zero data without extra muxing.
                        rdata_q <= '0;
                        if (addr_bad(s_araddr)) begin
                            state_q  <= ST_RESP;
                            rvalid_q <= 1'b1;
                            rresp_q  <= RESP_SLVERR;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            we_q    <= 1'b0;
                            addr_q  <= s_araddr[11:0];
                        end
                    end
                end

                ST_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (reg_gnt_i) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        req_q   <= 1'b0;
                        if (is_wr_q) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_SLVERR;
                        end else begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= RESP_SLVERR;
                        end
                    end
                end

                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_wr_q) begin
                        // The write error flag is valid exactly one cycle after grant.
                        state_q  <= ST_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
                    end else if (reg_rvalid_i) begin
                        state_q  <= ST_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= reg_rdata_i;
                        rresp_q  <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q  <= ST_RESP;
                        rvalid_q <= 1'b1;
                        rresp_q  <= RESP_SLVERR;
                    end
                end

                ST_RESP: begin
                    if (is_wr_q ? b_hs : r_hs) begin
                        state_q   <= ST_IDLE;
                        bvalid_q  <= 1'b0;
                        rvalid_q  <= 1'b0;
                        prio_wr_q <= !is_wr_q;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hp_vpu_axil_csr_bridge.sv
// -----------------------------------------------------------------------------
// tb_hp_vpu_axil_csr_bridge
//
// Drives AXI4-Lite reads and writes into the bridge. A behavioural CSR device
// sits behind it with configurable grant and response delays. Each response is
// compared with a reference model: a word array plus the address, error,
// latency and timeout rules of the bridge.
// -----------------------------------------------------------------------------
module tb_hp_vpu_axil_csr_bridge;

    localparam int AW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_awvalid = 1'b0, s_awready;
    logic [AW-1:0] s_awaddr = '0;
    logic          s_wvalid = 1'b0, s_wready;
    logic [31:0]   s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_bvalid, s_bready = 1'b1;
    logic [1:0]    s_bresp;
    logic          s_arvalid = 1'b0, s_arready;
    logic [AW-1:0] s_araddr = '0;
    logic          s_rvalid, s_rready = 1'b1;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          reg_req_o, reg_gnt_i, reg_we_o;
    logic [11:0]   reg_addr_o;
    logic [31:0]   reg_wdata_o;
    logic [3:0]    reg_be_o;
    logic [31:0]   reg_rdata_i;
    logic          reg_rvalid_i, reg_error_i;

    always #5 clk = ~clk;

    hp_vpu_axil_csr_bridge #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .reg_req_o(reg_req_o), .reg_gnt_i(reg_gnt_i), .reg_we_o(reg_we_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
        .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i), .reg_error_i(reg_error_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // CSR device and reference model helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] init_word(input int i);
        if (i == 0)  return 32'h48500006;
        if (i == 63) return 32'hDEADBEEF;
        return 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    function automatic bit csr_err(input logic [11:0] a);
        return (a == 12'h0FC) || (a[11:8] == 4'hE);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        req_log[$];
    logic [31:0] ref_mem[1024];
    int          gnt_dly  = 0;
    int          rsp_dly  = 0;
    bit          no_grant = 1'b0;
    int          req_hi   = 0;

    // CSR device: grants after gnt_dly cycles of request, answers writes on
    // the cycle after grant and reads rsp_dly cycles later.
    initial begin
        logic [31:0] dev_mem[1024];
        int   ph;
        int   cnt;
        req_t cur;
        ph = 0;
        cnt = 0;
        cur = '{we: 1'b0, addr: 12'h0, wdata: 32'h0, be: 4'h0};
        for (int i = 0; i < 1024; i++) dev_mem[i] = init_word(i);
        reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
            if (!rst_n) begin
                ph = 0;
                continue;
            end
            if (reg_req_o) req_hi++;
            if (ph == 0 && reg_req_o && !no_grant) begin
                cnt = gnt_dly;
                ph = 1;
            end
            if (ph == 1) begin
                if (cnt == 0) begin
                    reg_gnt_i = 1'b1;
                    cur = '{we: reg_we_o, addr: reg_addr_o, wdata: reg_wdata_o, be: reg_be_o};
                    req_log.push_back(cur);
                    cnt = rsp_dly;
                    ph = 2;
                end else cnt--;
            end else if (ph == 2) begin
                if (cur.we) begin
                    reg_error_i = csr_err(cur.addr);
                    if (!csr_err(cur.addr))
                        dev_mem[cur.addr[11:2]] = merge(dev_mem[cur.addr[11:2]], cur.wdata, cur.be);
                    ph = 0;
                end else if (cnt == 0) begin
                    reg_rvalid_i = 1'b1;
                    reg_rdata_i = dev_mem[cur.addr[11:2]];
                    reg_error_i = csr_err(cur.addr);
                    ph = 0;
                end else cnt--;
            end
        end
    end

    // ------------------------------------------------------------------
    // AXI master tasks
    // ------------------------------------------------------------------
    task automatic axi_read(input logic [AW-1:0] a, input int start_dly, input int bp,
                            input bit chk_lat, input int exp_lat,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        int lat;
        logic hs;
        repeat (start_dly) begin @(posedge clk); #1; end
        s_araddr = a; s_arvalid = 1'b1; s_rready = (bp == 0); n = 0;
        forever begin
            @(negedge clk); hs = s_arready;
            @(posedge clk); #1;
            if (hs) break;
            n++;
            if (n > 200) begin chk("ar_hs_bound", 0, 1); break; end
        end
        s_arvalid = 1'b0;
        lat = 1; n = 0;
        while (!s_rvalid && n < 200) begin @(posedge clk); #1; lat++; n++; end
        if (!s_rvalid) chk("r_valid_bound", 0, 1);
        if (chk_lat) chk("r_latency", lat, exp_lat);
        d = s_rdata; r = s_rresp;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("r_hold_valid", s_rvalid, 1);
            chk("r_hold_data", s_rdata, d);
            chk("r_hold_resp", s_rresp, r);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        chk("r_valid_drop", s_rvalid, 0);
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int daw, input int dw, input int bp,
                             input bit chk_lat, input int exp_lat, output logic [1:0] r);
        int cyc;
        int n;
        int lat;
        bit aw_done, w_done, hsa, hsw;
        aw_done = 0; w_done = 0; cyc = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_bready = (bp == 0);
        while (!(aw_done && w_done) && cyc < 200) begin
            s_awvalid = !aw_done && (cyc >= daw);
            s_wvalid  = !w_done && (cyc >= dw);
            @(negedge clk);
            hsa = s_awvalid && s_awready;
            hsw = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (hsa) aw_done = 1;
            if (hsw) w_done = 1;
            cyc++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_bound", 0, 1);
        lat = 0; n = 0;
        while (!s_bvalid && n < 200) begin @(posedge clk); #1; lat++; n++; end
        if (!s_bvalid) chk("b_valid_bound", 0, 1);
        if (chk_lat) chk("b_latency", lat, exp_lat);
        r = s_bresp;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("b_hold_valid", s_bvalid, 1);
            chk("b_hold_resp", s_bresp, r);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        chk("b_valid_drop", s_bvalid, 0);
    endtask

    // ------------------------------------------------------------------
    // Model-checked single transactions
    // ------------------------------------------------------------------
    task automatic ref_read(input logic [AW-1:0] a, input int bp);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int  el, base, nreq;
        bit  bad;
        bad  = (a[1:0] != 2'b00) || (a[AW-1:12] != '0);
        base = req_log.size();
        nreq = 1;
        ed   = ref_mem[a[11:2]];
        er   = csr_err(a[11:0]) ? 2'b10 : 2'b00;
        el   = 3 + gnt_dly + rsp_dly;
        if (bad) begin
            ed = '0; er = 2'b10; el = 1; nreq = 0;
        end else if (no_grant) begin
            ed = '0; er = 2'b10; el = 1 + TO; nreq = 0;
        end
        axi_read(a, 0, bp, 1'b1, el, d, r);
        chk("rd_data", d, ed);
        chk("rd_resp", r, er);
        chk("rd_nreq", req_log.size() - base, nreq);
        if (nreq == 1 && req_log.size() > base) begin
            chk("rd_req_we", req_log[base].we, 0);
            chk("rd_req_addr", req_log[base].addr, a[11:0]);
        end
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int daw, input int dw, input int bp);
        logic [1:0] r, er;
        int  el, base, nreq;
        bit  bad;
        bad  = (a[1:0] != 2'b00) || (a[AW-1:12] != '0);
        base = req_log.size();
        nreq = 1;
        er   = csr_err(a[11:0]) ? 2'b10 : 2'b00;
        el   = 3 + gnt_dly;
        if (bad) begin
            er = 2'b10; el = 1; nreq = 0;
        end else if (no_grant) begin
            er = 2'b10; el = 1 + TO; nreq = 0;
        end
        if (nreq == 1 && !csr_err(a[11:0])) ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, s);
        axi_write(a, d, s, daw, dw, bp, 1'b1, el, r);
        chk("wr_resp", r, er);
        chk("wr_nreq", req_log.size() - base, nreq);
        if (nreq == 1 && req_log.size() > base) begin
            chk("wr_req_we", req_log[base].we, 1);
            chk("wr_req_addr", req_log[base].addr, a[11:0]);
            chk("wr_req_wdata", req_log[base].wdata, d);
            chk("wr_req_be", req_log[base].be, s);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d2;
        logic [1:0]  r1, r2;
        logic [AW-1:0] a;
        logic [9:0]  idx;
        int base, kind, base_hi, seen;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", s_awready, 1);
        chk("rst_wready", s_wready, 1);
        chk("rst_arready", s_arready, 1);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_req", reg_req_o, 0);
        chk("rst_we", reg_we_o, 0);
        chk("rst_addr", reg_addr_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_be", reg_be_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Both candidates pending after reset: the read goes first.
        base = req_log.size();
        fork
            axi_write(16'h0080, 32'h0000_0003, 4'hF, 0, 0, 0, 1'b0, 0, r1);
            axi_read(16'h0000, 1, 0, 1'b0, 0, d2, r2);
        join
        ref_mem[32] = 32'h0000_0003;
        chk("prioA_nreq", req_log.size() - base, 2);
        chk("prioA_first_we", req_log[base].we, 0);
        chk("prioA_second_we", req_log[base+1].we, 1);
        chk("prioA_rdata", d2, 32'h48500006);
        chk("prioA_rresp", r2, 0);
        chk("prioA_bresp", r1, 0);

        ref_read(16'h0000, 0);

        // After a read, a tie goes to the write.
        base = req_log.size();
        fork
            axi_write(16'h0084, 32'h1122_3344, 4'h5, 0, 0, 0, 1'b0, 0, r1);
            axi_read(16'h0080, 1, 0, 1'b0, 0, d2, r2);
        join
        ref_mem[33] = merge(ref_mem[33], 32'h1122_3344, 4'h5);
        chk("prioB_nreq", req_log.size() - base, 2);
        chk("prioB_first_we", req_log[base].we, 1);
        chk("prioB_second_we", req_log[base+1].we, 0);
        chk("prioB_rdata", d2, 32'h0000_0003);
        chk("prioB_bresp", r1, 0);
        ref_read(16'h0084, 0);

        // W ahead of AW, CSR error responses, address errors.
        ref_write(16'h0080, 32'h0000_0003, 4'hF, 2, 0, 0);
        ref_read(16'h00FC, 0);
        ref_write(16'h00FC, 32'h0BAD_0BAD, 4'hF, 0, 1, 0);
        ref_read(16'h00FC, 0);
        ref_read(16'h0002, 0);
        ref_read(16'h1000, 0);
        ref_write(16'h0041, 32'h1234_5678, 4'hF, 0, 0, 0);

        // CSR never grants: timeout, with the read response back-pressured.
        no_grant = 1'b1;
        base_hi = req_hi;
        ref_read(16'h0010, 5);
        chk("to_rd_req_cycles", req_hi - base_hi, TO);
        base_hi = req_hi;
        ref_write(16'h0014, 32'hCAFE_F00D, 4'hF, 1, 0, 3);
        chk("to_wr_req_cycles", req_hi - base_hi, TO);
        no_grant = 1'b0;

        // Randomized traffic with random CSR delays and back-pressure.
        for (int t = 0; t < 80; t++) begin
            gnt_dly = $urandom_range(0, 3);
            rsp_dly = $urandom_range(0, 3);
            kind = $urandom_range(0, 7);
            idx = 10'($urandom_range(0, 63));
            if (kind == 2) idx = 10'($urandom_range(10'h380, 10'h3FF));
            a = {4'h0, idx, 2'b00};
            if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 1) a[AW-1:12] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1)
                ref_read(a, $urandom_range(0, 2));
            else
                ref_write(a, $urandom, 4'($urandom_range(1, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        gnt_dly = 0;
        rsp_dly = 0;

        // Asynchronous reset in the middle of a stalled read.
        no_grant = 1'b1;
        s_araddr = 16'h0020; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req_before_rst", reg_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", reg_req_o, 0);
        chk("mid_rst_arready", s_arready, 1);
        chk("mid_rst_rvalid", s_rvalid, 0);
        chk("mid_rst_addr", reg_addr_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_grant = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (s_rvalid || reg_req_o) seen++;
        end
        chk("mid_rst_no_response", seen, 0);
        ref_read(16'h0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got %0d checks expected completion", n_chk);
        $fatal(1);
    end

endmodule
